// File: rtl/dpram_pkg.sv
// ---------------------------------------------------------------------------
// dpram_pkg
// Shared definitions for the dual-port RAM self-test block: FSM state
// encoding, pattern selector codes and the pattern generator function.
// ---------------------------------------------------------------------------
package dpram_pkg;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // Pattern selector codes as seen on pattern_sel
    typedef enum logic [1:0] {
        PAT_INC  = 2'd0,   // word = address
        PAT_INV  = 2'd1,   // word = ~address
        PAT_CHK  = 2'd2,   // 0xAA.. on even addresses, 0x55.. on odd
        PAT_ONES = 2'd3    // all ones
    } pat_sel_e;

    // Widest word the generator produces; DATA_W is limited to this
    localparam int PAT_W = 32;

    // Pattern generator. It always works at PAT_W bits; callers take the low
    // DATA_W bits with a size cast, which gives exactly the zero-extend /
    // truncate behaviour for every pattern (inversion and the fixed
    // checkerboard constants are bitwise, so truncation commutes with them).
    function automatic logic [PAT_W-1:0] pat(input logic [PAT_W-1:0] addr,
                                             input pat_sel_e          sel);
        logic [PAT_W-1:0] res;
        res = '0;
        case (sel)
            PAT_INC:  res = addr;
            PAT_INV:  res = ~addr;
            PAT_CHK:  res = addr[0] ? 32'h5555_5555 : 32'hAAAA_AAAA;
            PAT_ONES: res = '1;
            default:  res = '0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/dpram_sdp.sv
// ---------------------------------------------------------------------------
// dpram_sdp
// Inferred simple dual-port RAM: one synchronous write port, one registered
// read port. READ_LAT=1 returns data one cycle after the address; READ_LAT=2
// adds an output register behind the read register.
// ---------------------------------------------------------------------------
module dpram_sdp #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 8,
    parameter int READ_LAT = 1
) (
    input  logic              sys_clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];
    logic [DATA_W-1:0] r_rd;

    // Write port
    // NOTE: the storage array has no reset branch; a reset on it would stop
    // the tools from mapping it onto block RAM, and nothing relies on its
    // contents before the sequencer has written them.
    // NOTE: sequential state is always assigned with <= so every register
    // samples its inputs as they were before the edge, independent of
    // statement order.
    always_ff @(posedge sys_clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    // Read port register (first cycle of read latency)
    always_ff @(posedge sys_clk) begin
        r_rd <= r_mem[raddr];
    end

    generate
        if (READ_LAT == 2) begin : g_out_reg
            logic [DATA_W-1:0] r_rd_q;

            // Extra output register for the two-cycle read variant
            always_ff @(posedge sys_clk) begin
                r_rd_q <= r_rd;
            end

            assign rdata = r_rd_q;
        end else begin : g_no_out_reg
            assign rdata = r_rd;
        end
    endgenerate

endmodule

// File: rtl/dpram_bist_ctrl.sv
// ---------------------------------------------------------------------------
// dpram_bist_ctrl
// Write-then-readback self test around a simple dual-port RAM. A start pulse
// in IDLE fills every word with the selected pattern, then reads every word
// back, counts mismatches, records the first failing address and reports
// pass/fail with a one-cycle done pulse.
//
// Build option: define DPRAM_ERR_INJECT_EN to add the err_inject input,
// which corrupts bit 0 of the word written at address 0 when latched high.
// ---------------------------------------------------------------------------
module dpram_bist_ctrl
    import dpram_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 8,
    parameter int READ_LAT = 1
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              start,
    input  logic [1:0]        pattern_sel,
`ifdef DPRAM_ERR_INJECT_EN
    input  logic              err_inject,
`endif
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W:0]   err_cnt,
    output logic [ADDR_W-1:0] first_err_addr
);

    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);
    localparam logic [1:0]        DRAIN_END = 2'(READ_LAT - 1);

    // FSM
    state_e            r_state;
    state_e            w_next_state;
    logic              w_accept;
    logic              w_we;
    logic              w_issue;
    logic              w_busy;

    // Counters and latched settings
    logic [ADDR_W-1:0] r_wr_addr;
    logic [ADDR_W-1:0] r_rd_addr;
    logic [1:0]        r_drain_cnt;
    pat_sel_e          r_pat_sel;

    // Read-side delay line, one stage per cycle of RAM read latency
    logic [READ_LAT-1:0] r_vld_pipe;
    logic [ADDR_W-1:0]   r_addr_pipe [READ_LAT];

    // Data paths
    logic [DATA_W-1:0] w_pat_wr;
    logic [DATA_W-1:0] w_wdata;
    logic [DATA_W-1:0] w_rdata;
    logic [DATA_W-1:0] w_exp;
    logic [ADDR_W-1:0] w_cmp_addr;
    logic              w_cmp_vld;
    logic              w_mismatch;

    // Results
    logic [ADDR_W:0]   r_err_cnt;
    logic [ADDR_W-1:0] r_first_err;
    logic              r_pass;
    logic              r_done;

    // State register
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode and per-state strobes
    // NOTE: every signal written here gets a default before the case so no
    // path leaves one unassigned, which would otherwise infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_we         = 1'b0;
        w_issue      = 1'b0;
        w_busy       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_next_state = ST_WRITE;
                end
            end
            ST_WRITE: begin
                w_we   = 1'b1;
                w_busy = 1'b1;
                if (r_wr_addr == '1) begin
                    w_next_state = ST_READ;
                end
            end
            ST_READ: begin
                w_issue = 1'b1;
                w_busy  = 1'b1;
                if (r_rd_addr == '1) begin
                    w_next_state = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                w_busy = 1'b1;
                if (r_drain_cnt == DRAIN_END) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Address counters, drain counter and pattern latch
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_wr_addr   <= '0;
            r_rd_addr   <= '0;
            r_drain_cnt <= '0;
            r_pat_sel   <= PAT_INC;
        end else begin
            if (w_accept) begin
                r_wr_addr <= '0;
                r_rd_addr <= '0;
                r_pat_sel <= pat_sel_e'(pattern_sel);
            end
            // Both address counters wrap to 0 after the last word; the
            // wrapped value is never used because the FSM has moved on.
            if (w_we) begin
                r_wr_addr <= r_wr_addr + ADDR_ONE;
            end
            if (w_issue) begin
                r_rd_addr <= r_rd_addr + ADDR_ONE;
            end
            r_drain_cnt <= (r_state == ST_DRAIN) ? r_drain_cnt + 2'd1 : 2'd0;
        end
    end

    // Write data: the selected pattern for the current write address
    assign w_pat_wr = DATA_W'(pat(PAT_W'(r_wr_addr), r_pat_sel));

`ifdef DPRAM_ERR_INJECT_EN
    logic r_inject;

    // Latch the injection request together with the other test settings
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_inject <= 1'b0;
        end else if (w_accept) begin
            r_inject <= err_inject;
        end
    end

    // Corrupt bit 0 of the word at address 0 so readback must flag it
    assign w_wdata = w_pat_wr ^ DATA_W'(r_inject && (r_wr_addr == '0));
`else
    assign w_wdata = w_pat_wr;
`endif

    dpram_sdp #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .READ_LAT(READ_LAT)
    ) u_ram (
        .sys_clk(sys_clk),
        .we     (w_we),
        .waddr  (r_wr_addr),
        .wdata  (w_wdata),
        .raddr  (r_rd_addr),
        .rdata  (w_rdata)
    );

    // Delay the issued read address and its valid bit to meet the RAM data
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_vld_pipe <= '0;
            for (int i = 0; i < READ_LAT; i++) begin
                r_addr_pipe[i] <= '0;
            end
        end else begin
            r_vld_pipe[0]  <= w_issue;
            r_addr_pipe[0] <= r_rd_addr;
            for (int i = 1; i < READ_LAT; i++) begin
                r_vld_pipe[i]  <= r_vld_pipe[i-1];
                r_addr_pipe[i] <= r_addr_pipe[i-1];
            end
        end
    end

    // Compare returning data against the pattern for its own address
    assign w_cmp_vld  = r_vld_pipe[READ_LAT-1];
    assign w_cmp_addr = r_addr_pipe[READ_LAT-1];
    assign w_exp      = DATA_W'(pat(PAT_W'(w_cmp_addr), r_pat_sel));
    assign w_mismatch = w_cmp_vld && (w_rdata != w_exp);

    // Error count, first failing address, pass flag and done pulse
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_err_cnt   <= '0;
            r_first_err <= '0;
            r_pass      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= (r_state == ST_DONE);
            if (w_accept) begin
                r_err_cnt   <= '0;
                r_first_err <= '0;
                r_pass      <= 1'b0;
            end else if (w_mismatch) begin
                r_err_cnt <= r_err_cnt + CNT_ONE;
                if (r_err_cnt == '0) begin
                    r_first_err <= w_cmp_addr;
                end
            end
            // All compares have retired by DONE, so the count is final here
            if (r_state == ST_DONE) begin
                r_pass <= (r_err_cnt == '0);
            end
        end
    end

    assign busy           = w_busy;
    assign done           = r_done;
    assign pass           = r_pass;
    assign err_cnt        = r_err_cnt;
    assign first_err_addr = r_first_err;

endmodule

// File: doc/dpram_bist_ctrl.md
Name: dpram_bist_ctrl

Overview:
Parametrised successor to the fixed two-port RAM demo. It contains a simple dual-port RAM with one write port and one read port, and drives it from a built-in write-then-readback sequencer. The sequencer fills the whole RAM with a selectable pattern, then reads every word back, compares each word against the expected value and reports an error count, the first failing address and a pass/fail flag. It is the top-level demo block and is driven by a board button or a testbench.

Parameters:
DATA_W, 8, RAM word width (1..32)
ADDR_W, 8, RAM address width; depth = 2**ADDR_W
READ_LAT, 1, read latency of the RAM in cycles; only 1 or 2 are legal (2 adds an output register)

Ports:
sys_clk  in  1  system clock; all logic sits on its rising edge
sys_rst  in  1  synchronous, active-high reset
start  in  1  single-cycle request; sampled only in IDLE
pattern_sel  in  2  pattern code, latched on an accepted start
busy  out  1  high while a test runs
done  out  1  one-cycle pulse when a test finishes
pass  out  1  1 = last test had no errors; held until the next accepted start
err_cnt  out  ADDR_W+1  number of mismatching words in the last test
first_err_addr  out  ADDR_W  address of the first mismatch; 0 if there was none

Behaviour:
- Reset: if sys_rst=1 at a clock edge, the FSM goes to IDLE and busy, done, pass, err_cnt and first_err_addr all become 0. Internal counters and the read pipeline are cleared. RAM contents are not cleared.
- Reset mid-test: the test is aborted immediately, no done pulse is produced and the results stay at 0.
- FSM states: IDLE, WRITE, READ, DRAIN, DONE.
  - IDLE -> WRITE when start=1. On that edge: latch pattern_sel, set wr_addr=0, set rd_addr=0, clear err_cnt, clear first_err_addr, clear pass.
  - start is ignored in every state other than IDLE.
- WRITE: one word is written per cycle at addresses 0..2**ADDR_W-1, with data = pat(addr). After the last address the FSM moves to READ. The address counter wraps to 0 and that wrap is not written.
- READ: one read is issued per cycle at addresses 0..2**ADDR_W-1. The address and a valid bit are delayed READ_LAT cycles so each returned word is compared against pat(delayed address). After the last address is issued the FSM moves to DRAIN.
- DRAIN: lasts READ_LAT cycles so the in-flight compares retire, then the FSM moves to DONE.
- DONE: lasts one cycle. done=1, pass=(err_cnt==0), then the FSM returns to IDLE.
- busy is 1 in WRITE, READ and DRAIN, and 0 in IDLE and DONE.
- Latency: from the start edge to the done pulse is 2*2**ADDR_W + READ_LAT + 1 cycles.
- Compare: on each valid compare with a mismatch, err_cnt increments. first_err_addr loads the mismatching address only when err_cnt==0 before that increment. err_cnt cannot overflow because its maximum value is 2**ADDR_W.
- Pattern generator pat(a), where a is zero-extended or truncated to DATA_W:
  - 0: a (incrementing)
  - 1: ~a
  - 2: checkerboard, 0xAA.. for even a and 0x55.. for odd a, truncated to DATA_W
  - 3: all ones
- Port overlap: the write and read phases never overlap, so read-during-write to the same address never happens and its behaviour is unspecified.

Optional Feature:
DPRAM_ERR_INJECT_EN
- Defined: adds input port err_inject (1 bit), latched on an accepted start. When the latched value is 1, the word written at address 0 has bit 0 inverted. The readback must then give err_cnt=1, first_err_addr=0 and pass=0.
- Undefined: the port does not exist and no inversion logic is built.

Decomposition:
- Package dpram_pkg holds:
  - FSM state encodings
  - pattern code constants (PAT_INC, PAT_INV, PAT_CHK, PAT_ONES)
  - the pattern function pat(addr, sel), parametrised on DATA_W
- Sub-module dpram_sdp: an inferred simple dual-port RAM with parameters DATA_W, ADDR_W and READ_LAT, and ports we, waddr, wdata, raddr, rdata.
- The controller itself holds only the FSM, the counters, the delay pipeline and the compare logic.

Test Plan:
- ADDR_W=4, DATA_W=8, READ_LAT=1, pattern 0, pulse start: done fires 34 cycles after start, pass=1, err_cnt=0, first_err_addr=0; busy is high for exactly 33 cycles.
- ADDR_W=4, READ_LAT=2, patterns 1, 2 and 3 run back to back: each run gives done 35 cycles after its start and pass=1; readback data at address 3 is 0xFC, 0x55 and 0xFF respectively.
- Force the RAM word at address 5 to a wrong value during READ using a hierarchical force on dpram_sdp: err_cnt=1, first_err_addr=5, pass=0.
- Assert sys_rst=1 for one cycle at cycle 10 of WRITE: next cycle busy=0 with state IDLE, no done pulse, err_cnt=0; a following start completes normally with pass=1.
- Pulse start again while busy=1: it is ignored and the total latency is unchanged; a start pulse during the DONE cycle is also ignored.
- With DPRAM_ERR_INJECT_EN defined, err_inject=1, pattern 0: err_cnt=1, first_err_addr=0, pass=0. With err_inject=0 the same run gives pass=1.
